multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/mc_pkg.sv | 96 +++++++++
 rtl/alu_decoder.sv | 37 +++
 rtl/mc_branch_cond.sv | 30 +++
 rtl/multicycle_controller.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, internal ALU
// operation class, datapath mux selects, immediate/extend types and opcodes.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEM_ADR,
      S_MEM_READ,
      S_MEM_WB,
      S_MEM_WRITE,
      S_EXECUTE,
      S_JALR_ADR,
      S_JUMP,
      S_ALU_WB,
      S_BRANCH,
      S_TRAP
   } state_t;

   typedef enum logic [1:0] {
      ALU_OP_ADD   = 2'b00,
      ALU_OP_SCMP  = 2'b01,
      ALU_OP_FUNCT = 2'b10,
      ALU_OP_UCMP  = 2'b11
   } alu_op_t;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_U = 3'b011,
      IMM_J = 3'b100
   } imm_src_t;

   typedef enum logic [2:0] {
      EXT_W  = 3'b000,
      EXT_B  = 3'b001,
      EXT_H  = 3'b010,
      EXT_BU = 3'b101,
      EXT_HU = 3'b110
   } ext_t;

   typedef enum logic [1:0] {
      SRC_A_PC    = 2'b00,
      SRC_A_OLDPC = 2'b01,
      SRC_A_RS1   = 2'b10,
      SRC_A_ZERO  = 2'b11
   } src_a_t;

   typedef enum logic [1:0] {
      SRC_B_RS2  = 2'b00,
      SRC_B_IMM  = 2'b01,
      SRC_B_FOUR = 2'b10
   } src_b_t;

   typedef enum logic [1:0] {
      RES_ALUOUT = 2'b00,
      RES_MEM    = 2'b01,
      RES_ALU    = 2'b10
   } result_src_t;

   // Major opcodes recognised by the controller
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // ALU control codes driven onto alu_control_o
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;

   // Load funct3 -> extend unit control
   function automatic ext_t load_extend(input logic [2:0] funct3);
      case (funct3)
         3'b000:  return EXT_B;
         3'b001:  return EXT_H;
         3'b100:  return EXT_BU;
         3'b101:  return EXT_HU;
         default: return EXT_W;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the controller's operation class plus instruction fields
// onto the ALU control code. Both compare classes subtract; the branch unit
// reads signed or unsigned meaning out of the resulting flags.
module alu_decoder
   import mc_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       op_5,
   output logic [3:0] alu_control
);

   // Combinational operation select
   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALU_OP_ADD:  alu_control = ALU_ADD;
         ALU_OP_SCMP: alu_control = ALU_SUB;
         ALU_OP_UCMP: alu_control = ALU_SUB;
         default: begin
            case (funct3)
               // only the register form (op bit 5 set) can subtract
               3'b000:  alu_control = (funct7_5 && op_5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_control = ALU_SLL;
               3'b010:  alu_control = ALU_SLT;
               3'b011:  alu_control = ALU_SLTU;
               3'b100:  alu_control = ALU_XOR;
               3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_control = ALU_OR;
               default: alu_control = ALU_AND;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/mc_branch_cond.sv
// Branch condition: decides taken/not-taken from funct3 and the {O,N,Z,C}
// flags of the rs1 - rs2 subtraction.
module mc_branch_cond (
   input  logic [2:0] funct3,
   input  logic [3:0] onzc,
   output logic       taken
);

   logic flag_o;
   logic flag_n;
   logic flag_z;
   logic flag_c;

   assign {flag_o, flag_n, flag_z, flag_c} = onzc;

   // Condition table; funct3 010/011 are not branches and never take
   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = flag_z;
         3'b001:  taken = ~flag_z;
         3'b100:  taken = flag_n ^ flag_o;
         3'b101:  taken = ~(flag_n ^ flag_o);
         3'b110:  taken = ~flag_c;
         3'b111:  taken = flag_c;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V controller: Moore FSM sequencing fetch, decode, memory,
// execute, jump and branch steps, with strobes forced low during reset.
module multicycle_controller
   import mc_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [6:0] op_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7_5_i,
   input  logic [3:0] onzc_i,
   input  logic       mem_ready_i,
   output logic       mem_req_o,
   output logic       memory_write_o,
   output logic       adr_source_o,
   output logic       ir_write_o,
   output logic       pc_write_o,
   output logic       reg_write_o,
   output logic [1:0] alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [1:0] result_source_o,
   output logic [3:0] alu_control_o,
   output logic [2:0] immediate_source_o,
   output logic [2:0] result_extend_control_o,
   output logic       retire_o,
   output logic       illegal_o
);

   localparam int NSTROBE = 6;

   state_t      state_reg;
   state_t      state_next;
   alu_op_t     alu_op;
   src_a_t      src_a;
   src_b_t      src_b;
   result_src_t result_src;
   imm_src_t    imm_src;
   ext_t        ext;
   logic        mem_req;
   logic        memory_write;
   logic        adr_source;
   logic        ir_write;
   logic        pc_write;
   logic        reg_write;
   logic        retire;
   logic        taken;

   logic is_load, is_store, is_r, is_i_alu, is_lui, is_auipc;
   logic is_jal, is_jalr, is_branch;

   assign is_load   = (op_i == OP_LOAD);
   assign is_store  = (op_i == OP_STORE);
   assign is_r      = (op_i == OP_R);
   assign is_i_alu  = (op_i == OP_I_ALU);
   assign is_lui    = (op_i == OP_LUI);
   assign is_auipc  = (op_i == OP_AUIPC);
   assign is_jal    = (op_i == OP_JAL);
   assign is_jalr   = (op_i == OP_JALR);
   assign is_branch = (op_i == OP_BRANCH);

   mc_branch_cond u_branch_cond (
      .funct3 (funct3_i),
      .onzc   (onzc_i),
      .taken  (taken)
   );

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (funct3_i),
      .funct7_5    (funct7_5_i),
      .op_5        (op_i[5]),
      .alu_control (alu_control_o)
   );

   // State register; reset lands in FETCH immediately, even mid-wait
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_reg <= S_FETCH;
      else         state_reg <= state_next;
   end

   // Next-state and per-state datapath controls
   always_comb begin
      state_next   = state_reg;
      mem_req      = 1'b0;
      memory_write = 1'b0;
      adr_source   = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      reg_write    = 1'b0;
      retire       = 1'b0;
      alu_op       = ALU_OP_ADD;
      src_a        = SRC_A_PC;
      src_b        = SRC_B_RS2;
      result_src   = RES_ALUOUT;
      imm_src      = IMM_I;
      ext          = EXT_W;
      case (state_reg)
         S_FETCH: begin
            mem_req    = 1'b1;
            src_b      = SRC_B_FOUR;
            result_src = RES_ALU;
            if (mem_ready_i) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            // precompute the branch/jal target into ALUOut
            src_a   = SRC_A_OLDPC;
            src_b   = SRC_B_IMM;
            imm_src = is_branch ? IMM_B : IMM_J;
            if (is_load || is_store)                      state_next = S_MEM_ADR;
            else if (is_r || is_i_alu || is_lui || is_auipc) state_next = S_EXECUTE;
            else if (is_jal)                              state_next = S_JUMP;
            else if (is_jalr)                             state_next = S_JALR_ADR;
            else if (is_branch)                           state_next = S_BRANCH;
            else                                          state_next = S_TRAP;
         end
         S_MEM_ADR: begin
            src_a      = SRC_A_RS1;
            src_b      = SRC_B_IMM;
            imm_src    = is_store ? IMM_S : IMM_I;
            state_next = is_store ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            mem_req    = 1'b1;
            adr_source = 1'b1;
            if (mem_ready_i) state_next = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            result_src = RES_MEM;
            ext        = load_extend(funct3_i);
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_MEM_WRITE: begin
            mem_req      = 1'b1;
            memory_write = 1'b1;
            adr_source   = 1'b1;
            if (mem_ready_i) begin
               retire     = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_EXECUTE: begin
            if (is_lui) begin
               src_a   = SRC_A_ZERO;
               src_b   = SRC_B_IMM;
               imm_src = IMM_U;
            end else if (is_auipc) begin
               src_a   = SRC_A_OLDPC;
               src_b   = SRC_B_IMM;
               imm_src = IMM_U;
            end else begin
               src_a  = SRC_A_RS1;
               src_b  = is_r ? SRC_B_RS2 : SRC_B_IMM;
               alu_op = ALU_OP_FUNCT;
            end
            state_next = S_ALU_WB;
         end
         S_JALR_ADR: begin
            src_a      = SRC_A_RS1;
            src_b      = SRC_B_IMM;
            state_next = S_JUMP;
         end
         S_JUMP: begin
            // PC takes the target in ALUOut while the ALU forms OldPC + 4
            pc_write   = 1'b1;
            src_a      = SRC_A_OLDPC;
            src_b      = SRC_B_FOUR;
            state_next = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_BRANCH: begin
            src_a      = SRC_A_RS1;
            src_b      = SRC_B_RS2;
            alu_op     = funct3_i[1] ? ALU_OP_UCMP : ALU_OP_SCMP;
            pc_write   = taken;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_TRAP: begin
            state_next = S_TRAP;
         end
         default: begin
            state_next = S_FETCH;
         end
      endcase
   end

   // Force every strobe low while reset is held, independent of the clock
   logic [NSTROBE-1:0] strobe_raw;
   logic [NSTROBE-1:0] strobe_gated;

   assign strobe_raw = {mem_req, memory_write, ir_write, pc_write, reg_write, retire};

   for (genvar gi = 0; gi < NSTROBE; gi++) begin : g_gate
      assign strobe_gated[gi] = strobe_raw[gi] & rst_ni;
   end

   assign {mem_req_o, memory_write_o, ir_write_o, pc_write_o, reg_write_o, retire_o} = strobe_gated;

   assign adr_source_o            = adr_source;
   assign alu_src_a_o             = src_a;
   assign alu_src_b_o             = src_b;
   assign result_source_o         = result_src;
   assign immediate_source_o      = imm_src;
   assign result_extend_control_o = ext;
   // reset drives the state to FETCH at once, so this clears with it
   assign illegal_o               = (state_reg == S_TRAP);

endmodule
